tdm_mux_4x1: RTL
================

Name: tdm_mux_4x1

Overview:
- Time-division transmitter for the 2-input, 4-output demux path. It gathers one bit from each of 4 channels and sends them round-robin as a data bit `d` plus a 2-bit select `x`.
- Drop-in source for `demux_2x4` at the receiving end: `d` drives the demux data input and `x` drives its select.
- Adds a per-channel request/acknowledge capture stage, a slot timer and a frame marker, so the demux side can tell valid slots from empty ones.

Parameters:
- SLOT_CYCLES, default 1: clock cycles per slot; legal range 1..255.
- DIV_W, default 8: width of the slot divider counter; must satisfy 2^DIV_W >= SLOT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; level-sensitive.
- ch_in  in  4  data bit per channel; ch_in[i] belongs to channel i.
- ch_req  in  4  per-channel request to load ch_in[i].
- ch_ack  out  4  one-cycle pulse: channel i's bit was captured.
- d  out  1  serial data bit for the current slot.
- x  out  2  slot/channel select for the current slot.
- d_valid  out  1  high when d carries captured data in this slot.
- frame_start  out  1  one-cycle pulse on the first cycle of each slot 0 while RUN.

Behaviour:
- Clock, reset and output timing
  - Single clock. Reset is asynchronous and active-low: rst_n low immediately forces all state and outputs.
  - Reset values: d=0, x=2'b00, d_valid=0, frame_start=0, ch_ack=4'b0000, pending=0, hold=0, div=0, state=IDLE.
  - All outputs are registered.
- Capture
  - Rule: on a clk edge where ch_req[i]=1 and pending[i]=0, hold[i] <= ch_in[i], pending[i] <= 1, ch_ack[i] <= 1 for exactly one cycle.
  - If ch_req[i]=1 while pending[i]=1, nothing is captured and no ack is issued; the requester holds req until it sees ack.
  - Capture runs in both IDLE and RUN.
- State machine: IDLE, RUN.
  - IDLE: d=0, x=0, d_valid=0, div=0.
  - IDLE -> RUN on en=1. The first RUN cycle is a slot boundary for slot 0.
  - RUN -> IDLE on en=0, effective at the next edge. An in-flight slot is abandoned; the pending bit of the channel being shown stays cleared, because its data was already driven.
- Slot timer
  - div counts 0..SLOT_CYCLES-1 and wraps.
  - A slot boundary occurs when div wraps, and on IDLE->RUN entry.
  - The slot index advances 0->1->2->3->0.
- At a slot boundary for slot s:
  - x <= s.
  - d <= pending[s] ? hold[s] : 0.
  - d_valid <= pending[s].
  - pending[s] <= 0.
  - frame_start <= (s==0).
  - d, x and d_valid are held for the whole slot; frame_start lasts 1 cycle.
- Drain beats capture: if the same edge drains channel s and sees ch_req[s]=1, capture is not allowed on that edge because the old pending=1 is used. Capture happens on the next edge instead.
- Latency
  - With SLOT_CYCLES=1, one frame is 4 cycles.
  - Bit i captured at edge t appears on d at the next boundary for slot i. Worst case is 4*SLOT_CYCLES cycles after capture; the minimum is 1 cycle.
- Reset mid-operation: everything returns to reset values, including pending and hold. Queued bits are lost and no ack is reissued.
- x wraps 3->0 with no gap slot. frame_start fires on every slot-0 boundary, including the RUN entry.

Decomposition:
- Package tdm_pkg holds:
  - constants N_CH=4 and SEL_W=2;
  - the state enum {IDLE, RUN};
  - the slot index type (logic [SEL_W-1:0]).
- One natural sub-module, tdm_slot_timer:
  - owns div and the slot index;
  - outputs a boundary pulse and the slot index;
  - inputs are clk, rst_n, run.
- The top module keeps capture registers, the FSM and the output registers.

Test Plan:
1. Reset and idle: rst_n=0 then 1, en=0 -> d=0, x=00, d_valid=0, frame_start=0, ch_ack=0000 on every cycle.
2. Full frame: SLOT_CYCLES=1, ch_in=4'b1010, ch_req=1111 for 1 cycle, then en=1 -> ch_ack=1111 once; then x=00,01,10,11 with d=0,1,0,1 and d_valid=1 each; frame_start only at x=00. The next frame has d_valid=0 in all slots.
3. Sparse and slow: SLOT_CYCLES=3, only channel 2 requests with ch_in[2]=1 -> x is held 3 cycles per slot; d_valid=1 and d=1 only during x=10; d_valid=0 in the other slots.
4. Busy request: ch_req[1] held high with pending[1]=1 -> no ch_ack[1] until the slot-1 drain edge; ack arrives exactly 1 edge after the drain, and the new bit appears in the following frame.
5. Enable drop: en deasserted during slot 2 -> next cycle x=00, d=0, d_valid=0; pending of channel 3 is retained. Re-enable -> frame_start pulses, and channel 3 data appears at x=11.
6. Async reset mid-frame: rst_n pulsed low between edges during slot 1 with pending=1111 -> outputs clear immediately without waiting for a clock; after release with en=1, all slots show d_valid=0.

Source files
------------

// File: rtl/tdm_mux_4x1_pkg.sv
// Shared constants and types for the 4-channel TDM transmitter.
// Also holds the state enum and the slot index type.
package tdm_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_e;

    typedef logic [SEL_W-1:0] slot_t;

endpackage

// File: rtl/tdm_mux_4x1_if.sv
// Channel-side and line-side signals of the TDM transmitter.
// The slave modport is the transmitter itself; master is whoever drives it.
interface tdm_mux_4x1_if;
    import tdm_pkg::*;

    logic            en;
    logic [N_CH-1:0] ch_in;
    logic [N_CH-1:0] ch_req;
    logic [N_CH-1:0] ch_ack;
    logic            d;
    slot_t           x;
    logic            d_valid;
    logic            frame_start;

    modport master (
        output en, ch_in, ch_req,
        input  ch_ack, d, x, d_valid, frame_start
    );

    modport slave (
        input  en, ch_in, ch_req,
        output ch_ack, d, x, d_valid, frame_start
    );

endinterface

// File: rtl/tdm_mux_4x1_slot_timer.sv
// Slot divider and round-robin slot index for the TDM transmitter.
// The boundary pulse and slot index describe the edge about to happen.
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 1,
    parameter int DIV_W       = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  run,
    output logic  boundary,
    output slot_t slot
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOT_CYCLES - 1);

    logic [DIV_W-1:0] div_r;
    slot_t            slot_r;
    logic             active_r;
    logic             wrap_s;

    // Entering RUN always starts slot 0; otherwise advance on divider wrap.
    always_comb begin
        wrap_s   = (div_r == DIV_LAST);
        boundary = run & (~active_r | wrap_s);
        if (active_r) begin
            slot = slot_r + {{(SEL_W-1){1'b0}}, 1'b1};
        end else begin
            slot = {SEL_W{1'b0}};
        end
    end

    // Divider, current slot and "already running" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= {DIV_W{1'b0}};
            slot_r   <= {SEL_W{1'b0}};
            active_r <= 1'b0;
        end else if (!run) begin
            div_r    <= {DIV_W{1'b0}};
            slot_r   <= {SEL_W{1'b0}};
            active_r <= 1'b0;
        end else if (boundary) begin
            div_r    <= {DIV_W{1'b0}};
            slot_r   <= slot;
            active_r <= 1'b1;
        end else begin
            div_r    <= div_r + DIV_W'(1'b1);
            active_r <= 1'b1;
        end
    end

endmodule

// File: rtl/tdm_mux_4x1.sv
// Four-channel time-division transmitter feeding a 2x4 demux: request/ack
// capture per channel, IDLE/RUN control and registered d/x/d_valid/frame_start.
module tdm_mux_4x1
    import tdm_pkg::*;
#(
    parameter int SLOT_CYCLES = 1,
    parameter int DIV_W       = 8
) (
    input logic            clk,
    input logic            rst_n,
    tdm_mux_4x1_if.slave   bus
);

    tdm_state_e      state_r;
    tdm_state_e      state_next_s;
    logic            run_s;
    logic            boundary_s;
    slot_t           slot_s;

    logic [N_CH-1:0] pending_r;
    logic [N_CH-1:0] hold_r;
    logic [N_CH-1:0] ack_r;
    logic [N_CH-1:0] capture_s;
    logic [N_CH-1:0] drain_s;

    logic            d_r;
    slot_t           x_r;
    logic            d_valid_r;
    logic            frame_start_r;

    // Next-state logic: en is level-sensitive in both states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.en) state_next_s = RUN;
                else        state_next_s = IDLE;
            end
            RUN: begin
                if (bus.en) state_next_s = RUN;
                else        state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    assign run_s = (state_next_s == RUN);

    tdm_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DIV_W       (DIV_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_s),
        .boundary (boundary_s),
        .slot     (slot_s)
    );

    // Capture looks at the old pending bit, so a drain on the same edge wins.
    always_comb begin
        capture_s = bus.ch_req & ~pending_r;
        drain_s   = {N_CH{1'b0}};
        if (boundary_s) begin
            drain_s[slot_s] = 1'b1;
        end else begin
            drain_s = {N_CH{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-channel capture registers and one-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {N_CH{1'b0}};
            hold_r    <= {N_CH{1'b0}};
            ack_r     <= {N_CH{1'b0}};
        end else begin
            ack_r     <= capture_s;
            pending_r <= capture_s | (pending_r & ~drain_s);
            hold_r    <= (capture_s & bus.ch_in) | (~capture_s & hold_r);
        end
    end

    // Line outputs: loaded at slot boundaries, cleared whenever heading to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r           <= 1'b0;
            x_r           <= {SEL_W{1'b0}};
            d_valid_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (state_next_s == IDLE) begin
            d_r           <= 1'b0;
            x_r           <= {SEL_W{1'b0}};
            d_valid_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (boundary_s) begin
            x_r           <= slot_s;
            d_valid_r     <= pending_r[slot_s];
            d_r           <= pending_r[slot_s] & hold_r[slot_s];
            frame_start_r <= (slot_s == {SEL_W{1'b0}});
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign bus.ch_ack      = ack_r;
    assign bus.d           = d_r;
    assign bus.x           = x_r;
    assign bus.d_valid     = d_valid_r;
    assign bus.frame_start = frame_start_r;

endmodule
